imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Program loader at the front of the single-cycle CPU. Accepts a byte stream (16-bit word count header, then big-endian 32-bit instruction words), writes each word into the instruction memory write port, and holds the CPU in reset until the image is complete. It then releases the CPU's active-low reset. It is the writer side of the instruction-fetch path: the CPU reads instruction memory, and this block fills it.

## Interface
- ADDR_WIDTH, 8, instruction memory word-address width; capacity 2^ADDR_WIDTH words
- HOLD_CYCLES, 4, cycles cpu_reset_n stays low after the last write (≥1)
- CLK  in  1  clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load session
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready at a rising edge
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  word data
- cpu_reset_n  out  1  active-low reset to the CPU core
- busy  out  1  session in progress (HDR_HI through HOLD)
- done  out  1  image loaded, CPU running
- err  out  1  header word count exceeds capacity

## Operation
- All outputs are registered. Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, busy=0, done=0, err=0. The state is IDLE.
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, HOLD, RUN, ERROR.
- IDLE: start → HDR_HI.
- HDR_HI: accept one byte as N[15:8] → HDR_LO.
- HDR_LO: accept one byte as N[7:0], then branch:
  - N > 2^ADDR_WIDTH → ERROR.
  - N == 0 → HOLD.
  - Otherwise → DATA, with word index 0 and byte index 0.
- DATA: accept bytes b0..b3 into word {b0,b1,b2,b3}, with b0 as bits [31:24]. After the 4th byte → WRITE.
- WRITE: lasts one cycle.
  - mem_we=1, mem_addr=word index, mem_wdata=assembled word.
  - The word index then increments. If it equals N → HOLD; otherwise → DATA.
- HOLD: counts HOLD_CYCLES cycles → RUN.
- RUN: cpu_reset_n=1, done=1. start → HDR_HI (reload) and clears done. cpu_reset_n goes low on the same edge.
- ERROR: err=1 and in_ready=0. start → HDR_HI and clears err. Only Reset or start leaves ERROR.
- start is ignored in HDR_HI, HDR_LO, DATA, WRITE and HOLD.
- in_ready=1 only in HDR_HI, HDR_LO and DATA. It is 0 in every other state, including WRITE.
- cpu_reset_n=0 in every state except RUN.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Width rules:
  - N is a 16-bit unsigned value.
  - The internal word counter is ADDR_WIDTH+1 bits, so N = 2^ADDR_WIDTH is legal and the final address is 2^ADDR_WIDTH−1. No wrap-around occurs.
  - The byte index is 2 bits.
- Asserting Reset mid-session forces the reset values immediately, independent of CLK. A partially assembled word is discarded; words already written stay in memory.

## Timing
- Each byte transfer takes one cycle when in_valid is held high. Peak throughput is 4 bytes per 5 cycles, because WRITE deasserts in_ready.
- mem_we is high in the cycle immediately after the edge that accepts b3.
- Let the last write cycle be T, or the HDR_LO accept edge for N=0.
  - HOLD occupies cycles T+1..T+HOLD_CYCLES.
  - cpu_reset_n and done rise at the edge ending cycle T+HOLD_CYCLES.
  - busy falls at that same edge.
- busy rises on the edge that samples start in IDLE, RUN or ERROR.
- When start and in_valid are both high in IDLE, the byte is not consumed: in_ready is 0 in IDLE.

## Test plan
- Basic load, ADDR_WIDTH=8, HOLD_CYCLES=4:
  - Stimulus: start, then bytes 00 02 | 20 08 00 05 | AC 08 00 00 with in_valid held high.
  - Required: mem_we pulses write addr0=0x20080005 and addr1=0xAC080000. cpu_reset_n rises 5 cycles after the second mem_we cycle begins. done=1, busy=0.
- Stalled source:
  - Stimulus: the same image with in_valid low for 3 cycles between every byte.
  - Required: identical writes and data. No byte is lost or duplicated. in_ready=0 during each WRITE cycle.
- Empty image:
  - Stimulus: start, then header 00 00.
  - Required: no mem_we. cpu_reset_n rises 4 cycles after the HDR_LO accept edge.
- Overflow:
  - Stimulus: header 01 01 (N=257).
  - Required: err=1, in_ready=0, cpu_reset_n=0.
  - Then header 01 00 (N=256) with start and 1024 bytes: last write at addr 0xFF, err=0, done=1.
- Async reset mid-word:
  - Stimulus: drop Reset between clock edges after 2 data bytes of word 1.
  - Required: all outputs take reset values immediately, with no further mem_we. A fresh start plus image loads correctly.
- Reload from RUN:
  - Stimulus: pulse start while done=1.
  - Required: cpu_reset_n=0 and done=0 on the next edge. The new image overwrites addr0. cpu_reset_n is released again after HOLD_CYCLES.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream, instruction-memory write and CPU-control signals of the boot loader
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  i_start;
  logic                  i_in_valid;
  logic [7:0]            i_in_data;
  logic                  o_in_ready;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [31:0]           o_mem_wdata;
  logic                  o_cpu_reset_n;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_err;
  modport master (
    output i_start, i_in_valid, i_in_data,
    input  o_in_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_reset_n, o_busy, o_done, o_err
  );
  modport slave (
    input  i_start, i_in_valid, i_in_data,
    output o_in_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_reset_n, o_busy, o_done, o_err
  );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed big-endian word image into instruction memory, then releases the CPU
module imem_boot_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int HOLD_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  imem_boot_loader_if.slave    bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, HOLD, RUN, ERROR} state_t;

  state_t                r_state;
  logic [7:0]            r_nhi;
  logic [CW-1:0]         r_n;
  logic [CW-1:0]         r_widx;
  logic [1:0]            r_bidx;
  logic [23:0]           r_shift;
  logic [HW-1:0]         r_hold;
  logic                  r_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_rst_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_fire;
  logic [15:0]           w_n;
  logic [CW-1:0]         w_widx_nxt;

  assign w_fire     = bus.i_in_valid && r_ready;
  assign w_n        = {r_nhi, bus.i_in_data};
  assign w_widx_nxt = r_widx + CW'(1);

  // Session FSM; every output is a register updated on the transition into the state that owns it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_nhi       <= '0;
      r_n         <= '0;
      r_widx      <= '0;
      r_bidx      <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_ready     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE, RUN, ERROR: begin
          if (bus.i_start) begin
            r_state     <= HDR_HI;
            r_ready     <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
          end
        end
        HDR_HI: begin
          if (w_fire) begin
            r_nhi   <= bus.i_in_data;
            r_state <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (w_fire) begin
            if ({1'b0, w_n} > CAP) begin
              r_state <= ERROR;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else if (w_n == 16'd0) begin
              r_state <= HOLD;
              r_ready <= 1'b0;
              r_hold  <= '0;
            end else begin
              r_state <= DATA;
              r_n     <= w_n[CW-1:0];
              r_widx  <= '0;
              r_bidx  <= '0;
            end
          end
        end
        DATA: begin
          if (w_fire) begin
            r_bidx  <= r_bidx + 2'd1;
            r_shift <= {r_shift[15:0], bus.i_in_data};
            if (r_bidx == 2'd3) begin
              r_state <= WRITE;
              r_ready <= 1'b0;
              r_we    <= 1'b1;
              r_addr  <= r_widx[ADDR_WIDTH-1:0];
              r_wdata <= {r_shift, bus.i_in_data};
            end
          end
        end
        WRITE: begin
          r_widx <= w_widx_nxt;
          if (w_widx_nxt == r_n) begin
            r_state <= HOLD;
            r_hold  <= '0;
          end else begin
            r_state <= DATA;
            r_ready <= 1'b1;
          end
        end
        HOLD: begin
          if (r_hold == HW'(HOLD_CYCLES - 1)) begin
            r_state     <= RUN;
            r_cpu_rst_n <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_in_ready    = r_ready;
  assign bus.o_mem_we      = r_we;
  assign bus.o_mem_addr    = r_addr;
  assign bus.o_mem_wdata   = r_wdata;
  assign bus.o_cpu_reset_n = r_cpu_rst_n;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;
  assign bus.o_err         = r_err;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed images with a write scoreboard checked by an independent monitor
module tb_imem_boot_loader;
  localparam int AW = 8;
  localparam int HC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [AW+31:0] exp_q[$];

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_boot_loader #(.ADDR_WIDTH(AW), .HOLD_CYCLES(HC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pop one expected write per mem_we cycle; any write with an empty queue is an error
  always @(negedge clk) begin
    if (bus.o_mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.o_mem_addr, bus.o_mem_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.o_mem_addr), 64'(e[AW+31:32]));
        chk("wr_data", 64'(bus.o_mem_wdata), 64'(e[31:0]));
        chk("ready_in_write", 64'(bus.o_in_ready), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic push(input int a, input logic [31:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_in_valid = 1'b0;
    repeat (gap) tick();
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = b;
    for (int k = 0; k < 20 && !bus.o_in_ready; k++) tick();
    if (!bus.o_in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_accept: got in_ready 0 expected 1 within 20 cycles");
    end
    tick();
    bus.i_in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gap);
  endtask

  task automatic check_release(input int lows);
    for (int k = 0; k < lows; k++) begin
      tick();
      chk("cpu_held", 64'(bus.o_cpu_reset_n), 64'd0);
    end
    tick();
    chk("cpu_released", 64'(bus.o_cpu_reset_n), 64'd1);
    chk("done_set", 64'(bus.o_done), 64'd1);
    chk("busy_clear", 64'(bus.o_busy), 64'd0);
  endtask

  task automatic check_reset_vals;
    chk("rst_in_ready", 64'(bus.o_in_ready), 64'd0);
    chk("rst_mem_we", 64'(bus.o_mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.o_mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.o_mem_wdata), 64'd0);
    chk("rst_cpu_reset_n", 64'(bus.o_cpu_reset_n), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_done", 64'(bus.o_done), 64'd0);
    chk("rst_err", 64'(bus.o_err), 64'd0);
  endtask

  task automatic basic_image(input int gap);
    push(0, 32'h2008_0005);
    push(1, 32'hAC08_0000);
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_word(32'h2008_0005, gap);
    send_word(32'hAC08_0000, gap);
  endtask

  initial begin
    bus.i_start    = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = 8'h00;
    tick();
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    tick();

    // Basic load; start with in_valid already high must not consume the header byte
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = 8'h00;
    pulse_start();
    chk("busy_on_start", 64'(bus.o_busy), 64'd1);
    basic_image(0);
    check_release(HC);
    chk("basic_err", 64'(bus.o_err), 64'd0);

    // Reload from RUN overwrites addr0
    pulse_start();
    chk("reload_cpu_low", 64'(bus.o_cpu_reset_n), 64'd0);
    chk("reload_done_low", 64'(bus.o_done), 64'd0);
    chk("reload_busy", 64'(bus.o_busy), 64'd1);
    push(0, 32'hDEAD_BEEF);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hDEAD_BEEF, 0);
    check_release(HC);

    // Stalled source
    pulse_start();
    basic_image(3);
    check_release(HC);

    // Empty image: release HOLD_CYCLES edges after the HDR_LO accept edge
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_release(HC - 1);

    // Overflow then full-capacity image
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk("ovf_err", 64'(bus.o_err), 64'd1);
    chk("ovf_in_ready", 64'(bus.o_in_ready), 64'd0);
    chk("ovf_cpu", 64'(bus.o_cpu_reset_n), 64'd0);
    pulse_start();
    chk("ovf_err_cleared", 64'(bus.o_err), 64'd0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      logic [31:0] w;
      b = 8'(i);
      w = {b, ~b, 8'h5A, b ^ 8'hC3};
      push(i, w);
      send_word(w, 0);
    end
    check_release(HC);
    chk("full_err", 64'(bus.o_err), 64'd0);
    chk("full_last_addr", 64'(bus.o_mem_addr), 64'hFF);

    // Async reset after two bytes of word 1
    pulse_start();
    push(0, 32'h1122_3344);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    basic_image(0);
    check_release(HC);

    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
